// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control FSM and ALU decoder.
// Consumers: multicycle_controller, alu_decoder.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECR,
        EXECI,
        ALUWB,
        JAL,
        BEQ
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD  = 2'b00,
        ALUOP_SUB  = 2'b01,
        ALUOP_FUNC = 2'b10
    } alu_op_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic instr_legal(
        input logic [6:0] op,
        input logic [2:0] f3
    );
        logic ok;
        ok = 1'b0;
        case (op)
            OP_LW, OP_SW: ok = (f3 == 3'b010);
            OP_R, OP_I:   ok = f3 inside {3'b000, 3'b010, 3'b110, 3'b111};
            OP_BEQ:       ok = (f3 == 3'b000);
            OP_JAL:       ok = 1'b1;
            default:      ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALUOp/funct decode to ALUControl.
module alu_decoder
    import mc_ctrl_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNC: begin
                case (funct3)
                    // I-type addi has no sub form, hence op5
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM for the multi-cycle RV32I datapath.
// Optional MC_CTRL_PERF_CNT_EN adds cycle_cnt/instret_cnt.
module multicycle_controller
    import mc_ctrl_pkg::*;
#(
    parameter int OPCODE_WIDTH      = 7,
    parameter int FUNCT3_WIDTH      = 3,
    parameter int ALU_CONTROL_WIDTH = 3,
    parameter int RESULTSRC_WIDTH   = 2,
    parameter int IMMSRC_WIDTH      = 2,
    parameter int CNT_WIDTH         = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [OPCODE_WIDTH-1:0]      opcode,
    input  logic [FUNCT3_WIDTH-1:0]      funct3,
    input  logic                         funct7b5,
    input  logic                         zero,
    input  logic                         mem_ready,
    output logic                         PCWrite,
    output logic                         AdrSrc,
    output logic                         MemWrite,
    output logic                         IRWrite,
    output logic [RESULTSRC_WIDTH-1:0]   ResultSrc,
    output logic [1:0]                   ALUSrcA,
    output logic [1:0]                   ALUSrcB,
    output logic [IMMSRC_WIDTH-1:0]      ImmSrc,
    output logic                         RegWrite,
    output logic [ALU_CONTROL_WIDTH-1:0] ALUControl,
    output logic                         illegal_instr
`ifdef MC_CTRL_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]         cycle_cnt,
    output logic [CNT_WIDTH-1:0]         instret_cnt
`endif
);

    state_t  state_q;
    state_t  state_d;
    alu_op_t alu_op;
    logic    legal;

    assign legal = instr_legal(opcode, funct3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        PCWrite       = 1'b0;
        AdrSrc        = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        ResultSrc     = RES_ALUOUT;
        ALUSrcA       = SRCA_PC;
        ALUSrcB       = SRCB_RD2;
        RegWrite      = 1'b0;
        alu_op        = ALUOP_ADD;
        illegal_instr = 1'b0;
        unique case (state_q)
            FETCH: begin
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                if (mem_ready) state_d = DECODE;
            end
            DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                if (!legal) begin
                    // PC already advanced in FETCH: the instruction is skipped
                    illegal_instr = 1'b1;
                    state_d       = FETCH;
                end else begin
                    case (opcode)
                        OP_LW, OP_SW: state_d = MEMADR;
                        OP_R:         state_d = EXECR;
                        OP_I:         state_d = EXECI;
                        OP_JAL:       state_d = JAL;
                        OP_BEQ:       state_d = BEQ;
                        default:      state_d = FETCH;
                    endcase
                end
            end
            MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                state_d = (opcode == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
                state_d   = FETCH;
            end
            MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) state_d = FETCH;
            end
            EXECR: begin
                ALUSrcA = SRCA_RD1;
                alu_op  = ALUOP_FUNC;
                state_d = ALUWB;
            end
            EXECI: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALUOP_FUNC;
                state_d = ALUWB;
            end
            ALUWB: begin
                RegWrite = 1'b1;
                state_d  = FETCH;
            end
            JAL: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                PCWrite = 1'b1;
                state_d = ALUWB;
            end
            BEQ: begin
                ALUSrcA = SRCA_RD1;
                alu_op  = ALUOP_SUB;
                PCWrite = zero;
                state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
        // No architectural write may escape while reset is held
        if (!rst_n) begin
            PCWrite       = 1'b0;
            IRWrite       = 1'b0;
            RegWrite      = 1'b0;
            MemWrite      = 1'b0;
            illegal_instr = 1'b0;
        end
    end

    always_comb begin
        ImmSrc = IMM_I;
        unique case (1'b1)
            (opcode == OP_SW):  ImmSrc = IMM_S;
            (opcode == OP_BEQ): ImmSrc = IMM_B;
            (opcode == OP_JAL): ImmSrc = IMM_J;
            default:            ImmSrc = IMM_I;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (opcode[5]),
        .alu_control (ALUControl)
    );

`ifdef MC_CTRL_PERF_CNT_EN
    logic retire;

    assign retire = (state_d == FETCH) &&
                    (state_q inside {MEMWB, MEMWRITE, ALUWB, BEQ});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
            if (retire) instret_cnt <= instret_cnt + CNT_WIDTH'(1);
        end
    end
`else
    if (CNT_WIDTH < 1) begin : g_cnt_width_unused
    end
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed literal checks plus a randomized run against a per-instruction
// step-sequence model of the controller.
module tb_multicycle_controller;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_instr;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
`ifdef MC_CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    multicycle_controller dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .funct3        (funct3),
        .funct7b5      (funct7b5),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .PCWrite       (PCWrite),
        .AdrSrc        (AdrSrc),
        .MemWrite      (MemWrite),
        .IRWrite       (IRWrite),
        .ResultSrc     (ResultSrc),
        .ALUSrcA       (ALUSrcA),
        .ALUSrcB       (ALUSrcB),
        .ImmSrc        (ImmSrc),
        .RegWrite      (RegWrite),
        .ALUControl    (ALUControl),
        .illegal_instr (illegal_instr)
`ifdef MC_CTRL_PERF_CNT_EN
        ,
        .cycle_cnt     (cycle_cnt),
        .instret_cnt   (instret_cnt)
`endif
    );

    always #5 clk = ~clk;

    // {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,RegWrite,ALUControl,illegal}
    logic [16:0] act;
    assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                  ALUSrcB, ImmSrc, RegWrite, ALUControl, illegal_instr};

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [16:0] v;
        bit          wait_mem;
        bit          gate_fetch;
        bit          pcw_zero;
        string       nm;
    } step_t;

    function automatic logic [16:0] mk(
        input bit pcw, input bit adr, input bit mw, input bit irw,
        input logic [1:0] rs, input logic [1:0] a, input logic [1:0] b,
        input logic [1:0] imm, input bit rw, input logic [2:0] alu,
        input bit ill
    );
        return {pcw, adr, mw, irw, rs, a, b, imm, rw, alu, ill};
    endfunction

    function automatic step_t st(input logic [16:0] v, input bit w,
                                 input bit g, input bit pz, input string nm);
        step_t s;
        s.v = v; s.wait_mem = w; s.gate_fetch = g; s.pcw_zero = pz; s.nm = nm;
        return s;
    endfunction

    function automatic logic [1:0] imm_of(input logic [6:0] op);
        case (op)
            7'b0100011: return 2'b01;
            7'b1100011: return 2'b10;
            7'b1101111: return 2'b11;
            default:    return 2'b00;
        endcase
    endfunction

    // Operation named by funct3 (and funct7b5 for R-type only)
    function automatic logic [2:0] alu_func(input logic [6:0] op,
                                            input logic [2:0] f3,
                                            input logic f7);
        case (f3)
            3'b000:  return (op == 7'b0110011 && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            default: return 3'b010;
        endcase
    endfunction

    task automatic check(input logic [16:0] exp, input string nm);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic lit(input logic [16:0] exp, input string nm);
        #1 check(exp, nm);
        @(negedge clk);
    endtask

    task automatic fields(input logic [6:0] op, input logic [2:0] f3,
                          input logic f7);
        opcode = op; funct3 = f3; funct7b5 = f7;
    endtask

    // kind: 0 lw, 1 sw, 2 R, 3 I, 4 jal, 5 beq, 6 illegal
    task automatic gen(output int kind);
        logic [2:0] good [4];
        logic [2:0] bad  [4];
        logic [6:0] op;
        logic [2:0] f3;
        good = '{3'b000, 3'b010, 3'b110, 3'b111};
        bad  = '{3'b001, 3'b011, 3'b100, 3'b101};
        kind = $urandom_range(0, 6);
        f3 = good[$urandom_range(0, 3)];
        op = 7'b0;
        case (kind)
            0: begin op = 7'b0000011; f3 = 3'b010; end
            1: begin op = 7'b0100011; f3 = 3'b010; end
            2: op = 7'b0110011;
            3: op = 7'b0010011;
            4: begin op = 7'b1101111; f3 = 3'($urandom); end
            5: begin op = 7'b1100011; f3 = 3'b000; end
            default: begin
                case ($urandom_range(0, 2))
                    0: begin
                        do op = 7'($urandom);
                        while (op inside {7'b0000011, 7'b0100011, 7'b0110011,
                                          7'b0010011, 7'b1100011, 7'b1101111});
                        f3 = 3'($urandom);
                    end
                    1: begin
                        op = $urandom_range(0, 1) ? 7'b0110011 : 7'b0010011;
                        f3 = bad[$urandom_range(0, 3)];
                    end
                    default: begin
                        op = $urandom_range(0, 1) ? 7'b0000011 : 7'b0100011;
                        do f3 = 3'($urandom); while (f3 == 3'b010);
                    end
                endcase
            end
        endcase
        fields(op, f3, 1'($urandom));
    endtask

    task automatic build(input int kind, ref step_t q[$]);
        logic [1:0] im;
        logic [2:0] af;
        step_t wb;
        im = imm_of(opcode);
        af = alu_func(opcode, funct3, funct7b5);
        wb = st(mk(0,0,0,0,2'b00,2'b00,2'b00,im,1,3'b000,0), 0, 0, 0, "aluwb");
        q.push_back(st(mk(0,0,0,0,2'b10,2'b00,2'b10,im,0,3'b000,0), 1, 1, 0, "fetch"));
        q.push_back(st(mk(0,0,0,0,2'b00,2'b01,2'b01,im,0,3'b000,kind == 6),
                       0, 0, 0, "decode"));
        case (kind)
            0: begin
                q.push_back(st(mk(0,0,0,0,2'b00,2'b10,2'b01,im,0,3'b000,0), 0, 0, 0, "memadr"));
                q.push_back(st(mk(0,1,0,0,2'b00,2'b00,2'b00,im,0,3'b000,0), 1, 0, 0, "memread"));
                q.push_back(st(mk(0,0,0,0,2'b01,2'b00,2'b00,im,1,3'b000,0), 0, 0, 0, "memwb"));
            end
            1: begin
                q.push_back(st(mk(0,0,0,0,2'b00,2'b10,2'b01,im,0,3'b000,0), 0, 0, 0, "memadr"));
                q.push_back(st(mk(0,1,1,0,2'b00,2'b00,2'b00,im,0,3'b000,0), 1, 0, 0, "memwrite"));
            end
            2: begin
                q.push_back(st(mk(0,0,0,0,2'b00,2'b10,2'b00,im,0,af,0), 0, 0, 0, "execr"));
                q.push_back(wb);
            end
            3: begin
                q.push_back(st(mk(0,0,0,0,2'b00,2'b10,2'b01,im,0,af,0), 0, 0, 0, "execi"));
                q.push_back(wb);
            end
            4: begin
                q.push_back(st(mk(1,0,0,0,2'b00,2'b01,2'b10,im,0,3'b000,0), 0, 0, 0, "jal"));
                q.push_back(wb);
            end
            5: q.push_back(st(mk(0,0,0,0,2'b00,2'b10,2'b00,im,0,3'b001,0), 0, 0, 1, "beq"));
            default: ;
        endcase
    endtask

    initial begin
        step_t q[$];
        step_t h;
        logic [16:0] e;
        int kind;
        int cycles;
        int retired;
        int n_instr;
        clk = 0;
        rst_n = 0;
        fields(7'b0110011, 3'b000, 1'b0);
        mem_ready = 1;
        zero = 0;

        // Reset holds FETCH with every write enable forced off
        #1 check(mk(0,0,0,0,2'b10,2'b00,2'b10,2'b00,0,3'b000,0), "reset_state");
        @(negedge clk);
        rst_n = 1;

        // add x1,x2,x3 (0x003100B3) then sub
        lit(mk(1,0,0,1,2'b10,2'b00,2'b10,2'b00,0,3'b000,0), "add_fetch");
        lit(mk(0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,3'b000,0), "add_decode");
        lit(mk(0,0,0,0,2'b00,2'b10,2'b00,2'b00,0,3'b000,0), "add_execr");
        lit(mk(0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,3'b000,0), "add_aluwb");
        funct7b5 = 1;
        lit(mk(1,0,0,1,2'b10,2'b00,2'b10,2'b00,0,3'b000,0), "sub_fetch");
        lit(mk(0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,3'b000,0), "sub_decode");
        lit(mk(0,0,0,0,2'b00,2'b10,2'b00,2'b00,0,3'b001,0), "sub_execr");
        lit(mk(0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,3'b000,0), "sub_aluwb");

        // beq taken, then not taken
        fields(7'b1100011, 3'b000, 1'b0);
        zero = 1;
        lit(mk(1,0,0,1,2'b10,2'b00,2'b10,2'b10,0,3'b000,0), "beq_fetch");
        lit(mk(0,0,0,0,2'b00,2'b01,2'b01,2'b10,0,3'b000,0), "beq_decode");
        lit(mk(1,0,0,0,2'b00,2'b10,2'b00,2'b10,0,3'b001,0), "beq_taken");
        zero = 0;
        lit(mk(1,0,0,1,2'b10,2'b00,2'b10,2'b10,0,3'b000,0), "beq2_fetch");
        lit(mk(0,0,0,0,2'b00,2'b01,2'b01,2'b10,0,3'b000,0), "beq2_decode");
        lit(mk(0,0,0,0,2'b00,2'b10,2'b00,2'b10,0,3'b001,0), "beq_not_taken");

        // illegal opcode 0000000
        fields(7'b0000000, 3'b000, 1'b0);
        lit(mk(1,0,0,1,2'b10,2'b00,2'b10,2'b00,0,3'b000,0), "ill_fetch");
        lit(mk(0,0,0,0,2'b00,2'b01,2'b01,2'b00,0,3'b000,1), "ill_decode");

        // sw, reset dropped while MEMWRITE waits
        fields(7'b0100011, 3'b010, 1'b0);
        lit(mk(1,0,0,1,2'b10,2'b00,2'b10,2'b01,0,3'b000,0), "sw_fetch");
        lit(mk(0,0,0,0,2'b00,2'b01,2'b01,2'b01,0,3'b000,0), "sw_decode");
        lit(mk(0,0,0,0,2'b00,2'b10,2'b01,2'b01,0,3'b000,0), "sw_memadr");
        mem_ready = 0;
        lit(mk(0,1,1,0,2'b00,2'b00,2'b00,2'b01,0,3'b000,0), "sw_memwrite");
        #1 check(mk(0,1,1,0,2'b00,2'b00,2'b00,2'b01,0,3'b000,0), "sw_memwrite_hold");
        #2 rst_n = 0;
        mem_ready = 1;
        #1 check(mk(0,0,0,0,2'b10,2'b00,2'b10,2'b01,0,3'b000,0), "async_reset");
`ifdef MC_CTRL_PERF_CNT_EN
        n_cmp++;
        if (cycle_cnt !== 0 || instret_cnt !== 0) begin
            n_bad++;
            $display("FAIL perf_reset: got %0d/%0d expected 0/0", cycle_cnt, instret_cnt);
        end
`endif
        @(negedge clk);
        rst_n = 1;

        // Randomized run against the step-sequence model
        cycles = 0;
        retired = 0;
        n_instr = 0;
        while (n_instr < 400 && cycles < 20000) begin
            if (q.size() == 0) begin
                gen(kind);
                build(kind, q);
            end
            mem_ready = ($urandom_range(0, 3) != 0);
            zero = 1'($urandom);
            h = q[0];
            e = h.v;
            if (h.gate_fetch) begin
                e[16] = mem_ready;
                e[13] = mem_ready;
            end
            if (h.pcw_zero) e[16] = zero;
            #1 check(e, h.nm);
            if (!(h.wait_mem && !mem_ready)) begin
                void'(q.pop_front());
                if (q.size() == 0) begin
                    n_instr++;
                    if (kind != 6) retired++;
                end
            end
            @(negedge clk);
            cycles++;
        end
        if (n_instr < 400) begin
            n_cmp++;
            n_bad++;
            $display("FAIL random_budget: got %0d instructions expected 400", n_instr);
        end
`ifdef MC_CTRL_PERF_CNT_EN
        n_cmp++;
        if (cycle_cnt !== 32'(cycles) || instret_cnt !== 32'(retired)) begin
            n_bad++;
            $display("FAIL perf_counts: got %0d/%0d expected %0d/%0d",
                     cycle_cnt, instret_cnt, cycles, retired);
        end
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Main control FSM plus ALU decoder for the multi-cycle RV32I core variant. It sequences the shared datapath (one memory, one ALU, register file, immediate generator) over several cycles per instruction, driving every select and write enable. The opcode and funct fields come from the instruction register. A memory handshake (mem_ready) stretches the fetch and memory-access states.

Parameters:
OPCODE_WIDTH, 7, opcode field width
FUNCT3_WIDTH, 3, funct3 width
ALU_CONTROL_WIDTH, 3, ALUControl width
RESULTSRC_WIDTH, 2, ResultSrc width
IMMSRC_WIDTH, 2, ImmSrc width
CNT_WIDTH, 32, perf counter width (optional feature only)

Ports:
clk  in  1  clock; one clock domain
rst_n  in  1  reset; asynchronous, active-low
opcode  in  7  IR[6:0]
funct3  in  3  IR[14:12]
funct7b5  in  1  IR[30]
zero  in  1  ALU zero flag
mem_ready  in  1  memory access complete this cycle
PCWrite  out  1  PC register enable
AdrSrc  out  1  0=PC, 1=ALUOut as memory address
MemWrite  out  1  memory write strobe
IRWrite  out  1  IR/OldPC load enable
ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
ALUSrcA  out  2  00=PC, 01=OldPC, 10=RD1
ALUSrcB  out  2  00=RD2, 01=ImmExt, 10=const 4
ImmSrc  out  2  00=I, 01=S, 10=B, 11=J
RegWrite  out  1  register-file write enable
ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
illegal_instr  out  1  one-cycle pulse on an unsupported encoding

Behaviour:
- Moore FSM with a registered state. Outputs are combinational from state (plus mem_ready/zero where noted). Unlisted outputs are 0 (selects 00).
- Supported instructions: lw (0000011, f3=010), sw (0100011, f3=010), R-type (0110011), I-ALU (0010011), beq (1100011, f3=000), jal (1101111). R/I funct3 must be one of 000, 010, 110, 111. Anything else is illegal.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, IRWrite=mem_ready, PCWrite=mem_ready. Goes to DECODE when mem_ready=1, otherwise stays.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (branch/jump target). Next state by opcode: lw/sw->MEMADR, R->EXECR, I->EXECI, jal->JAL, beq->BEQ. Illegal encodings pulse illegal_instr=1 and return to FETCH with no writes; the PC is already advanced, so the instruction is skipped.
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. lw->MEMREAD, sw->MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Goes to MEMWB on mem_ready, otherwise stays.
- MEMWB: ResultSrc=01, RegWrite=1. Goes to FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held until mem_ready. Goes to FETCH on mem_ready.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Goes to ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Goes to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Goes to FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1. Goes to ALUWB, which writes PC+4 into rd.
- BEQ: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, PCWrite=zero. Goes to FETCH.
- ImmSrc is decoded from opcode in every state: I for lw/I-ALU, S for sw, B for beq, J for jal, 00 otherwise.
- ALU decoder:
  - ALUOp 00 -> add; ALUOp 01 -> sub.
  - ALUOp 10, funct3 000: sub if opcode[5]&funct7b5, else add.
  - ALUOp 10, funct3 010/110/111: slt/or/and.
- Latency in cycles (mem_ready=1 throughout): lw 5, sw 4, R/I 4, jal 4, beq 3, illegal 2. Each wait cycle adds 1.
- Reset: asserting rst_n forces state to FETCH immediately, at any point including mid-access. While rst_n=0, PCWrite, IRWrite, RegWrite, MemWrite and illegal_instr are forced to 0. The first fetch happens on the first clk edge after release.
- mem_ready is ignored in states that do not access memory.

Optional Feature:
MC_CTRL_PERF_CNT_EN: adds outputs cycle_cnt[CNT_WIDTH] and instret_cnt[CNT_WIDTH], both reset to 0.
- cycle_cnt increments every clk while out of reset.
- instret_cnt increments on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ. The illegal path does not count.
- Both counters wrap modulo 2^CNT_WIDTH.
Without the macro, the ports and logic are absent.

Decomposition:
- Package mc_ctrl_pkg holds:
  - the state enum (FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, JAL, BEQ);
  - opcode constants;
  - ALUOp, ALUControl, ALUSrcA/B, ResultSrc and ImmSrc encodings.
- One sub-module, alu_decoder, which is combinational and maps ALUOp/funct3/funct7b5/opcode[5] to ALUControl.

Test Plan:
- Reset, mem_ready=1, add (0x003100B3): FETCH->DECODE->EXECR->ALUWB->FETCH. ALUControl=000 in EXECR; RegWrite=1 only in ALUWB. Repeat with sub (funct7b5=1): ALUControl=001.
- lw with mem_ready=0 for 3 cycles in MEMREAD: FSM holds MEMREAD, then MEMWB with RegWrite=1 and ResultSrc=01. Total 8 cycles.
- sw with mem_ready low for 2 cycles: MemWrite=1 and AdrSrc=1 for 3 cycles, then FETCH. RegWrite stays 0.
- beq with zero=1: PCWrite=1 and ALUControl=001 in BEQ. With zero=0: PCWrite=0. Total 3 cycles.
- Opcode 0000000: illegal_instr=1 for one cycle in DECODE, then back to FETCH. No RegWrite/MemWrite pulse.
- rst_n dropped mid-MEMWRITE: state goes to FETCH and MemWrite to 0 without waiting for clk. After release, a fetch proceeds normally. With MC_CTRL_PERF_CNT_EN, both counters read 0.
